// File: rtl/hsi_frame_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : hsi_frame_sched                                            |
// | Description : Frame scheduler around a fixed-latency RGB->HSI converter. |
// |               Credit-gated issue, SOF/EOL tag line, output FIFO.         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module hsi_frame_sched #(
    parameter int PIPE_LAT   = 6,
    parameter int FIFO_DEPTH = 16,
    parameter int IMG_W      = 640,
    parameter int IMG_H      = 480
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        frame_done,
    output logic        sync_err,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [23:0] s_rgb,
    output logic [7:0]  cv_R,
    output logic [7:0]  cv_G,
    output logic [7:0]  cv_B,
    output logic        cv_en,
    input  logic [8:0]  cv_H,
    input  logic [7:0]  cv_S,
    input  logic [7:0]  cv_I,
    input  logic        cv_hsi_en,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [24:0] m_hsi,
    output logic        m_sof,
    output logic        m_eol
);
    localparam int c_aw = $clog2(FIFO_DEPTH);
    localparam int c_cw = c_aw + 1;
    localparam int c_sw = c_cw + 1;
    localparam int c_xw = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int c_yw = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int c_bw = $clog2(PIPE_LAT + 2);
    localparam logic [c_xw-1:0] c_x_last    = c_xw'(IMG_W - 1);
    localparam logic [c_yw-1:0] c_y_last    = c_yw'(IMG_H - 1);
    localparam logic [c_bw-1:0] c_blank_end = c_bw'(PIPE_LAT + 1);
    localparam logic [c_sw-1:0] c_depth     = c_sw'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                     state_q, state_d;
    logic                       busy_q, busy_d;
    logic                       frame_done_q, frame_done_d;
    logic                       sync_err_q, sync_err_d;
    logic [c_xw-1:0]            x_q, x_d;
    logic [c_yw-1:0]            y_q, y_d;
    logic [c_cw-1:0]            inflight_q, inflight_d;
    logic [c_cw-1:0]            fifo_cnt_q, fifo_cnt_d;
    logic [c_aw-1:0]            wr_ptr_q, wr_ptr_d;
    logic [c_aw-1:0]            rd_ptr_q, rd_ptr_d;
    logic [23:0]                cv_rgb_q, cv_rgb_d;
    logic                       cv_en_q, cv_en_d;
    logic [1:0]                 cv_tag_q, cv_tag_d;
    logic [PIPE_LAT-1:0][2:0]   tag_line_q, tag_line_d;
    logic [c_bw-1:0]            blank_cnt_q, blank_cnt_d;
    logic [26:0]                fifo_mem_q [FIFO_DEPTH];

    logic                       w_accept;
    logic                       w_push;
    logic                       w_pop;
    logic                       w_blanking;
    logic [2:0]                 w_tag_end;
    logic [26:0]                w_head;
    logic [c_sw-1:0]            w_occupancy;

    // Credit check uses registered state only so s_ready never depends on s_valid
    assign w_occupancy = {1'b0, fifo_cnt_q} + {1'b0, inflight_q};
    assign s_ready     = (state_q == ST_RUN) && (w_occupancy < c_depth);
    assign w_accept    = s_valid & s_ready;
    assign w_tag_end   = tag_line_q[PIPE_LAT-1];
    assign w_push      = cv_hsi_en & w_tag_end[2];
    assign w_pop       = m_ready & (fifo_cnt_q != '0);
    assign w_blanking  = (blank_cnt_q != c_blank_end);
    assign w_head      = fifo_mem_q[rd_ptr_q];

    // Next-state logic: FSM, position counters, credit, issue, tag line, FIFO pointers
    always_comb begin
        state_d      = state_q;
        frame_done_d = 1'b0;
        x_d          = x_q;
        y_d          = y_q;
        inflight_d   = inflight_q;
        fifo_cnt_d   = fifo_cnt_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        cv_en_d      = w_accept;
        cv_rgb_d     = w_accept ? s_rgb : cv_rgb_q;
        cv_tag_d     = w_accept ? {(x_q == '0) && (y_q == '0), x_q == c_x_last} : cv_tag_q;
        blank_cnt_d  = w_blanking ? blank_cnt_q + 1'b1 : blank_cnt_q;
        sync_err_d   = sync_err_q | (cv_hsi_en & ~w_tag_end[2] & ~w_blanking);

        // Tag travels one stage behind cv_en so it meets cv_hsi_en at the line end
        tag_line_d[0] = {cv_en_q, cv_tag_q};
        for (int i = 1; i < PIPE_LAT; i++) begin
            tag_line_d[i] = tag_line_q[i-1];
        end

        if (w_accept) begin
            if (x_q == c_x_last) begin
                x_d = '0;
                y_d = (y_q == c_y_last) ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end

        case ({w_accept, w_push})
            2'b10:   inflight_d = inflight_q + 1'b1;
            2'b01:   inflight_d = inflight_q - 1'b1;
            default: inflight_d = inflight_q;
        endcase

        case ({w_push, w_pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + 1'b1;
            2'b01:   fifo_cnt_d = fifo_cnt_q - 1'b1;
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
        if (w_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (w_pop)  rd_ptr_d = rd_ptr_q + 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    x_d     = '0;
                    y_d     = '0;
                end
            end
            ST_RUN: begin
                if (w_accept && (x_q == c_x_last) && (y_q == c_y_last)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if ((inflight_q == '0) && (fifo_cnt_q == '0)) begin
                    state_d      = ST_IDLE;
                    frame_done_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // Control and datapath registers; reset aborts everything and restarts blanking
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            sync_err_q   <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
            inflight_q   <= '0;
            fifo_cnt_q   <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cv_rgb_q     <= '0;
            cv_en_q      <= 1'b0;
            cv_tag_q     <= '0;
            tag_line_q   <= '0;
            blank_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            sync_err_q   <= sync_err_d;
            x_q          <= x_d;
            y_q          <= y_d;
            inflight_q   <= inflight_d;
            fifo_cnt_q   <= fifo_cnt_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cv_rgb_q     <= cv_rgb_d;
            cv_en_q      <= cv_en_d;
            cv_tag_q     <= cv_tag_d;
            tag_line_q   <= tag_line_d;
            blank_cnt_q  <= blank_cnt_d;
        end
    end

    // FIFO storage; contents need no reset because the head is masked when empty
    always_ff @(posedge clk) begin
        if (w_push) begin
            fifo_mem_q[wr_ptr_q] <= {cv_H, cv_S, cv_I, w_tag_end[1:0]};
        end
    end

    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign sync_err   = sync_err_q;
    assign cv_R       = cv_rgb_q[23:16];
    assign cv_G       = cv_rgb_q[15:8];
    assign cv_B       = cv_rgb_q[7:0];
    assign cv_en      = cv_en_q;
    assign m_valid    = (fifo_cnt_q != '0);
    assign m_hsi      = m_valid ? w_head[26:2] : '0;
    assign m_sof      = m_valid & w_head[1];
    assign m_eol      = m_valid & w_head[0];

endmodule
`default_nettype wire

// File: tb/tb_hsi_frame_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_hsi_frame_sched                                         |
// | Description : Directed bench for hsi_frame_sched with a behavioural      |
// |               fixed-latency converter and an in-order scoreboard.        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_hsi_frame_sched;
    localparam int PL   = 6;
    localparam int FD   = 8;
    localparam int W    = 4;
    localparam int H    = 4;
    localparam int NPIX = W * H;

    typedef struct {
        logic [23:0] rgb;
        logic [8:0]  h;
        logic [7:0]  s;
        logic [7:0]  i;
        logic        sof;
        logic        eol;
    } vec_t;

    vec_t vec [NPIX];

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        s_valid = 1'b0;
    logic [23:0] s_rgb = '0;
    logic        m_ready = 1'b0;
    logic        inj = 1'b0;
    logic        busy, frame_done, sync_err, s_ready, cv_en, cv_hsi_en, m_valid, m_sof, m_eol;
    logic [7:0]  cv_R, cv_G, cv_B, cv_S, cv_I;
    logic [8:0]  cv_H;
    logic [24:0] m_hsi;

    int n_checks = 0;
    int n_errors = 0;
    int tcyc = 0;
    int pops = 0;
    int last_pop_cyc = 0;
    int exp_q [$];

    always #5 clk = ~clk;
    always @(posedge clk) tcyc++;

    hsi_frame_sched #(.PIPE_LAT(PL), .FIFO_DEPTH(FD), .IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .frame_done(frame_done),
        .sync_err(sync_err), .s_valid(s_valid), .s_ready(s_ready), .s_rgb(s_rgb),
        .cv_R(cv_R), .cv_G(cv_G), .cv_B(cv_B), .cv_en(cv_en), .cv_H(cv_H), .cv_S(cv_S),
        .cv_I(cv_I), .cv_hsi_en(cv_hsi_en), .m_valid(m_valid), .m_ready(m_ready),
        .m_hsi(m_hsi), .m_sof(m_sof), .m_eol(m_eol)
    );

    // Simplified converter: hue by dominant channel, S = max-min, I = mean
    function automatic logic [24:0] conv(input logic [23:0] c);
        logic [7:0] r, g, b, mx, mn;
        logic [9:0] sum;
        logic [8:0] hh;
        r = c[23:16]; g = c[15:8]; b = c[7:0];
        if (r >= g && r >= b) begin hh = 9'd0;   mx = r; end
        else if (g >= b)      begin hh = 9'd120; mx = g; end
        else                  begin hh = 9'd240; mx = b; end
        mn = (r <= g && r <= b) ? r : ((g <= b) ? g : b);
        sum = {2'b00, r} + {2'b00, g} + {2'b00, b};
        return {hh, 8'(mx - mn), 8'(sum / 3)};
    endfunction

    // Converter model is deliberately not reset, so aborted frames leave residue
    logic [PL-1:0] cp_en = '0;
    logic [24:0]   cp_d [PL];
    always @(posedge clk) begin
        cp_en    <= {cp_en[PL-2:0], cv_en};
        cp_d[0]  <= conv({cv_R, cv_G, cv_B});
        for (int k = 1; k < PL; k++) cp_d[k] <= cp_d[k-1];
    end
    assign cv_hsi_en = cp_en[PL-1] | inj;
    assign cv_H      = cp_d[PL-1][24:16];
    assign cv_S      = cp_d[PL-1][15:8];
    assign cv_I      = cp_d[PL-1][7:0];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every pop is compared in order against the pixel table
    always @(negedge clk) begin : mon
        int k;
        if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected pop: got %0h expected no data", m_hsi);
            end else begin
                k = exp_q.pop_front();
                chk($sformatf("m_hsi px%0d", k), m_hsi, {vec[k].h, vec[k].s, vec[k].i});
                chk($sformatf("m_sof px%0d", k), m_sof, vec[k].sof);
                chk($sformatf("m_eol px%0d", k), m_eol, vec[k].eol);
            end
            pops         <= pops + 1;
            last_pop_cyc <= tcyc;
        end
    end

    // mode 0: m_ready=1; 1: m_ready held low for 60 cycles; 2: m_ready toggles; 3: start pulsed mid-run
    task automatic run_frame(input int mode);
        int   idx, cyc, pops0, first_acc, first_mv, done_cyc;
        logic acc, prev_acc, exp_ready;
        logic [23:0] prev_rgb;
        idx = 0; cyc = 0; prev_acc = 1'b0; prev_rgb = '0;
        first_acc = -1; first_mv = -1; done_cyc = -1;
        pops0 = pops;
        for (int k = 0; k < NPIX; k++) exp_q.push_back(k);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (done_cyc < 0 && cyc < 3000) begin
            s_valid = (idx < NPIX);
            s_rgb   = vec[idx % NPIX].rgb;
            case (mode)
                1:       m_ready = (cyc >= 60);
                2:       m_ready = (cyc % 2 == 1);
                default: m_ready = 1'b1;
            endcase
            start = (mode == 3) && (cyc == 5);
            @(negedge clk);
            acc = s_valid & s_ready;
            exp_ready = (idx < NPIX) && ((idx - (pops - pops0)) < FD);
            chk("s_ready credit", s_ready, exp_ready);
            chk("cv_en after accept", cv_en, prev_acc);
            if (prev_acc) chk("cv_rgb issued", {cv_R, cv_G, cv_B}, prev_rgb);
            if (mode == 1 && cyc == 60) chk("accepts capped at depth", idx, FD);
            if (acc && first_acc < 0) first_acc = tcyc;
            if (m_valid && first_mv < 0) first_mv = tcyc;
            if (frame_done) begin
                done_cyc = tcyc;
                chk("busy low with frame_done", busy, 0);
            end else begin
                chk("busy during frame", busy, 1);
            end
            prev_acc = acc;
            prev_rgb = s_rgb;
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
            if (acc) idx++;
        end
        s_valid = 1'b0;
        chk("frame completed in budget", done_cyc >= 0, 1);
        chk("accepted pixels", idx, NPIX);
        chk("popped pixels", pops - pops0, NPIX);
        chk("frame_done after last pop", done_cyc - last_pop_cyc, 2);
        if (mode == 0) chk("accept to m_valid latency", first_mv - first_acc, PL + 2);
        @(negedge clk);
        chk("frame_done single cycle", frame_done, 0);
        chk("idle s_ready", s_ready, 0);
        chk("idle busy", busy, 0);
    endtask

    initial begin
        int idx, cyc;
        logic acc;
        vec[0]  = '{24'hFF0000, 9'd0,   8'd255, 8'd85,  1'b1, 1'b0};
        vec[1]  = '{24'h00FF00, 9'd120, 8'd255, 8'd85,  1'b0, 1'b0};
        vec[2]  = '{24'h0000FF, 9'd240, 8'd255, 8'd85,  1'b0, 1'b0};
        vec[3]  = '{24'h1E3C5A, 9'd240, 8'd60,  8'd60,  1'b0, 1'b1};
        vec[4]  = '{24'h5A3C1E, 9'd0,   8'd60,  8'd60,  1'b0, 1'b0};
        vec[5]  = '{24'h0AC814, 9'd120, 8'd190, 8'd76,  1'b0, 1'b0};
        vec[6]  = '{24'h000000, 9'd0,   8'd0,   8'd0,   1'b0, 1'b0};
        vec[7]  = '{24'hFFFFFF, 9'd0,   8'd0,   8'd255, 1'b0, 1'b1};
        vec[8]  = '{24'h030609, 9'd240, 8'd6,   8'd6,   1'b0, 1'b0};
        vec[9]  = '{24'h643264, 9'd0,   8'd50,  8'd83,  1'b0, 1'b0};
        vec[10] = '{24'h326464, 9'd120, 8'd50,  8'd83,  1'b0, 1'b0};
        vec[11] = '{24'h010203, 9'd240, 8'd2,   8'd2,   1'b0, 1'b1};
        vec[12] = '{24'hC86400, 9'd0,   8'd200, 8'd100, 1'b0, 1'b0};
        vec[13] = '{24'h00C864, 9'd120, 8'd200, 8'd100, 1'b0, 1'b0};
        vec[14] = '{24'h6400C8, 9'd240, 8'd200, 8'd100, 1'b0, 1'b0};
        vec[15] = '{24'h090909, 9'd0,   8'd0,   8'd9,   1'b0, 1'b1};

        // Reset state
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset busy", busy, 0);
        chk("reset frame_done", frame_done, 0);
        chk("reset sync_err", sync_err, 0);
        chk("reset s_ready", s_ready, 0);
        chk("reset cv_en", cv_en, 0);
        chk("reset cv_rgb", {cv_R, cv_G, cv_B}, 0);
        chk("reset m_valid", m_valid, 0);
        chk("reset m_head", {m_hsi, m_sof, m_eol}, 0);
        rst = 1'b0;
        repeat (PL + 3) @(posedge clk);
        #1;

        // T1: full-rate frame
        run_frame(0);

        // T4a: input offered while idle is refused
        s_valid = 1'b1;
        s_rgb   = 24'h123456;
        repeat (3) begin
            @(negedge clk);
            chk("idle refuses input", s_ready, 0);
            chk("idle cv_en", cv_en, 0);
        end
        s_valid = 1'b0;
        @(posedge clk); #1;

        // T4b: start during RUN ignored; T2: stalled sink; T3: toggling sink
        run_frame(3);
        run_frame(1);
        run_frame(2);
        chk("sync_err clear after normal frames", sync_err, 0);

        // T5: abort after 5 accepts, converter residue must be blanked
        start = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        s_valid = 1'b1;
        m_ready = 1'b1;
        idx = 0; cyc = 0;
        while (idx < 5 && cyc < 100) begin
            s_rgb = vec[idx].rgb;
            @(negedge clk);
            acc = s_valid & s_ready;
            @(posedge clk); #1;
            if (acc) idx++;
            cyc++;
        end
        chk("t5 accepts before abort", idx, 5);
        s_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("abort busy", busy, 0);
        chk("abort cv_en", cv_en, 0);
        chk("abort s_ready", s_ready, 0);
        chk("abort m_valid", m_valid, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        repeat (PL + 4) begin
            @(negedge clk);
            chk("residue not captured", m_valid, 0);
        end
        chk("residue ignored sync_err", sync_err, 0);
        run_frame(0);

        // T6: spurious converter strobe outside blanking is sticky
        repeat (3) @(posedge clk);
        #1 inj = 1'b1;
        @(posedge clk);
        #1 inj = 1'b0;
        @(negedge clk);
        chk("spurious strobe sets sync_err", sync_err, 1);
        repeat (5) @(negedge clk);
        chk("sync_err sticky", sync_err, 1);
        chk("spurious data dropped", m_valid, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("sync_err cleared by rst", sync_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
